// File: rtl/bcd_display_pkg.sv
// Shared constants and types for the 3-digit 7-segment display blocks.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_display_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 3;
  localparam int unsigned IDX_W = 2;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

  localparam logic [AN_W-1:0] ANODES_OFF = 3'b111;

  typedef struct packed {
    logic [NIB_W-1:0] hundreds;
    logic [NIB_W-1:0] tens;
    logic [NIB_W-1:0] ones;
  } bcd_word_t;

  typedef enum logic [IDX_W-1:0] {
    DIGIT_ONES     = 2'd0,
    DIGIT_TENS     = 2'd1,
    DIGIT_HUNDREDS = 2'd2
  } digit_e;

  // Scan order ones -> tens -> hundreds -> ones; the unused code 3 recovers to ones.
  function automatic digit_e next_digit(input digit_e d);
    case (d)
      DIGIT_ONES:     return DIGIT_TENS;
      DIGIT_TENS:     return DIGIT_HUNDREDS;
      default:        return DIGIT_ONES;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Packed BCD load bus between the binary-to-BCD converter and the display scanner.
interface bcd_display_scanner_if;
  import bcd_display_pkg::*;

  bcd_word_t bcd;
  logic      load;

  modport master (output bcd, output load);
  modport slave  (input  bcd, input  load);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-low 7-segment decoder; values above 9 show a dash.
module seg7_decoder
  import bcd_display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (nibble)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 3-digit common-anode display driver with ghost blanking
// and optional leading-zero suppression. an/seg are registered.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_display_scanner_if.slave  bus,
  output logic [AN_W-1:0]       an,
  output logic [SEG_W-1:0]      seg
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  bcd_word_t         val, val_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  digit_e            idx, idx_d;
  logic [AN_W-1:0]   an_d;
  logic [SEG_W-1:0]  seg_d;

  logic [NIB_W-1:0]  nibble_c;
  logic [SEG_W-1:0]  dec_seg_c;
  logic              ghost_c;
  logic              lead_zero_c;
  logic              blank_c;

  // Digit currently being scanned.
  always_comb begin
    nibble_c = val.ones;
    case (idx)
      DIGIT_TENS:     nibble_c = val.tens;
      DIGIT_HUNDREDS: nibble_c = val.hundreds;
      default:        nibble_c = val.ones;
    endcase
  end

  seg7_decoder u_dec (
    .nibble (nibble_c),
    .seg_c  (dec_seg_c)
  );

  // Anti-ghosting: anodes stay off for the first BLANK_CYCLES of every slot.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_ghost
      assign ghost_c = 1'b0;
    end else begin : g_ghost
      assign ghost_c = (cnt < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  // Only a literal zero nibble is a leading zero; invalid codes still display.
  always_comb begin
    lead_zero_c = 1'b0;
    case (idx)
      DIGIT_HUNDREDS: lead_zero_c = (val.hundreds == '0);
      DIGIT_TENS:     lead_zero_c = (val.hundreds == '0) && (val.tens == '0);
      default:        lead_zero_c = 1'b0;
    endcase
  end

  assign blank_c = ghost_c || (LZ_BLANK && lead_zero_c);

  // Next-state and next-output logic.
  always_comb begin
    val_d = val;
    cnt_d = cnt + CNT_W'(1);
    idx_d = idx;
    an_d  = ANODES_OFF;
    seg_d = SEG_BLANK;

    if (bus.load) begin
      val_d = bus.bcd;
    end

    if (cnt == CNT_LAST) begin
      cnt_d = '0;
      idx_d = next_digit(idx);
    end

    if (!blank_c) begin
      an_d  = ~(AN_W'(1) << idx);
      seg_d = dec_seg_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
      cnt <= '0;
      idx <= DIGIT_ONES;
      an  <= ANODES_OFF;
      seg <= SEG_BLANK;
    end else begin
      val <= val_d;
      cnt <= cnt_d;
      idx <= idx_d;
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench: time-indexed behavioural model of the display scan,
// compared every cycle for LZ_BLANK=1 and LZ_BLANK=0 instances.
module tb_bcd_display_scanner;
  import bcd_display_pkg::*;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLK   = 2;
  localparam int unsigned FRAME = 3 * DIV;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] an_lz, an_nz;
  logic [6:0] seg_lz, seg_nz;

  bcd_display_scanner_if bus ();

  bcd_display_scanner #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .LZ_BLANK(1'b1)) dut_lz (
    .clk (clk), .rst (rst), .bus (bus), .an (an_lz), .seg (seg_lz)
  );

  bcd_display_scanner #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .LZ_BLANK(1'b0)) dut_nz (
    .clk (clk), .rst (rst), .bus (bus), .an (an_nz), .seg (seg_nz)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got an=%b seg=%b, expected an=%b seg=%b at %0t",
                  name, act[9:7], act[6:0], exp[9:7], exp[6:0], $time);
  endtask

  // Output for display value v, t cycles after reset: slot = t/DIV, position = t%DIV.
  function automatic logic [9:0] model_out(input logic [11:0] v, input int unsigned t, input bit lz);
    int unsigned pos, dig;
    logic [3:0] nib;
    bit blank;
    pos   = t % DIV;
    dig   = (t / DIV) % 3;
    nib   = 4'((v >> (4 * dig)) & 12'hF);
    blank = (pos < BLK) ||
            (lz && ((dig == 2 && v[11:8] == 4'h0) || (dig == 1 && v[11:4] == 8'h00)));
    if (blank) return {3'b111, 7'b1111111};
    return {~(3'(1) << dig), seg_tab[nib]};
  endfunction

  logic [11:0] mval  = '0;
  int unsigned mtick = 0;
  bit          ready = 1'b0;
  logic [9:0]  exp_lz, exp_nz;

  always @(posedge clk) begin
    if (rst) begin
      exp_lz = {3'b111, 7'b1111111};
      exp_nz = {3'b111, 7'b1111111};
      mval   = '0;
      mtick  = 0;
      ready  = 1'b1;
    end else begin
      exp_lz = model_out(mval, mtick, 1'b1);
      exp_nz = model_out(mval, mtick, 1'b0);
      mtick++;
      if (bus.load) mval = bus.bcd;
    end
  end

  always @(negedge clk) begin
    if (ready) begin
      check("model_lz", {an_lz, seg_lz}, exp_lz);
      check("model_nz", {an_nz, seg_nz}, exp_nz);
      check("onehot_lz", {9'b0, ($countones(~an_lz) <= 1)}, 10'd1);
      check("onehot_nz", {9'b0, ($countones(~an_nz) <= 1)}, 10'd1);
    end
  end

  // Advance to a negedge where either the visible output (out_phase) or the
  // state about to be sampled sits at frame position ph.
  task automatic wait_mod(input int unsigned ph, input bit out_phase);
    bit hit = 1'b0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      @(negedge clk);
      if (out_phase ? (((mtick + FRAME - 1) % FRAME) == ph) : ((mtick % FRAME) == ph)) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      $display("FAIL wait_phase: phase %0d not reached, tick=%0d", ph, mtick);
    end
  endtask

  task automatic drive_load(input logic [11:0] v);
    bus.bcd  = bcd_word_t'(v);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    bus.load = 1'b1;
    bus.bcd  = bcd_word_t'(12'h999);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    bus.load = 1'b0;
    @(negedge clk); check("rst_out1", {an_lz, seg_lz}, {3'b111, 7'b1111111});
    @(negedge clk); check("rst_out2", {an_lz, seg_lz}, {3'b111, 7'b1111111});
    @(negedge clk); check("rst_out3", {an_lz, seg_lz}, {3'b110, 7'b1000000});

    drive_load(12'h255);
    wait_mod(3, 1'b1);  check("255_ones", {an_lz, seg_lz}, {3'b110, 7'b0010010});
    wait_mod(11, 1'b1); check("255_tens", {an_lz, seg_lz}, {3'b101, 7'b0010010});
    wait_mod(19, 1'b1); check("255_hund", {an_lz, seg_lz}, {3'b011, 7'b0100100});
    wait_mod(0, 1'b1);  check("255_ghost", {an_lz, seg_lz}, {3'b111, 7'b1111111});

    drive_load(12'h007);
    wait_mod(3, 1'b1);  check("007_ones", {an_lz, seg_lz}, {3'b110, 7'b1111000});
    wait_mod(11, 1'b1); check("007_tens_lz", {an_lz, seg_lz}, {3'b111, 7'b1111111});
                        check("007_tens_nz", {an_nz, seg_nz}, {3'b101, 7'b1000000});
    wait_mod(19, 1'b1); check("007_hund_lz", {an_lz, seg_lz}, {3'b111, 7'b1111111});
                        check("007_hund_nz", {an_nz, seg_nz}, {3'b011, 7'b1000000});

    drive_load(12'h0A3);
    wait_mod(11, 1'b1); check("0a3_tens", {an_lz, seg_lz}, {3'b101, 7'b0111111});
    wait_mod(19, 1'b1); check("0a3_hund", {an_lz, seg_lz}, {3'b111, 7'b1111111});
    wait_mod(3, 1'b1);  check("0a3_ones", {an_lz, seg_lz}, {3'b110, 7'b0110000});

    drive_load(12'h456);
    wait_mod(7, 1'b0);
    drive_load(12'h123);
    wait_mod(11, 1'b1); check("wrap_tens", {an_lz, seg_lz}, {3'b101, 7'b0100100});

    wait_mod(12, 1'b0);
    rst = 1'b1;
    @(negedge clk); check("rst_mid", {an_lz, seg_lz}, {3'b111, 7'b1111111});
    rst = 1'b0;
    @(negedge clk); check("rst_mid1", {an_lz, seg_lz}, {3'b111, 7'b1111111});
    @(negedge clk); check("rst_mid2", {an_lz, seg_lz}, {3'b111, 7'b1111111});
    @(negedge clk); check("rst_mid3", {an_lz, seg_lz}, {3'b110, 7'b1000000});

    // Random loads over a dozen frames, biased toward leading zeros.
    for (int i = 0; i < 12 * FRAME; i++) begin
      logic [11:0] v;
      v = 12'($urandom);
      if ($urandom_range(0, 2) == 0) v[11:8] = 4'h0;
      if ($urandom_range(0, 3) == 0) v[7:4]  = 4'h0;
      bus.bcd  = bcd_word_t'(v);
      bus.load = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    bus.load = 1'b0;
    repeat (FRAME) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
